serial_adder: RTL

- Bit-serial N-bit adder built around a single one-bit full-adder cell and a carry flip-flop.
- Accepts two N-bit operands and a carry-in through a valid/ready handshake.
- Adds the operands LSB-first, one bit per clock, and presents the N-bit sum and carry-out through a valid/ready handshake.
- Sits directly upstream of the one-bit full adder: it sequences operand bits into that cell and collects the sum and carry it produces.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_adder.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder, the arithmetic core of serial_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned COUNT_W = $clog2(WIDTH) + 1;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_sr_q, a_sr_d;
    logic [WIDTH-1:0]     b_sr_q, b_sr_d;
    logic [WIDTH-1:0]     sum_sr_q, sum_sr_d;
    logic                 carry_q, carry_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic cell_sum;
    logic cell_cout;

    fa_cell u_fa_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    sum_sr_d = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Shift-then-insert keeps the MSB write legal when WIDTH == 1.
                sum_sr_d            = sum_sr_q >> 1;
                sum_sr_d[WIDTH-1]   = cell_sum;
                a_sr_d              = a_sr_q >> 1;
                b_sr_d              = b_sr_q >> 1;
                carry_d             = cell_cout;
                count_d             = count_q + COUNT_W'(1);
                if (count_q == COUNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_sr_q;
    assign cout      = carry_q;

endmodule
